// File: rtl/processor_datapath.sv
// Register/bus datapath of the 8-bit processor: PC, MAR, IR, A, B, C, PR, MARR, CCR and the ALU.
// Loads land one cycle after their strobe edge; buses and ALU are combinational; no backpressure.
module processor_datapath #(
  parameter logic [7:0] IMM_VALUE = 8'h01,
  parameter logic [7:0] PC_RESET  = 8'h00,
  parameter logic [7:0] PR_RESET  = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       IR_Load,
  input  logic       MAR_Load,
  input  logic       MARR_Load,
  input  logic       PC_Load,
  input  logic       PC_Inc,
  input  logic       PR_Load,
  input  logic       A_Load,
  input  logic       B_Load,
  input  logic       C_Load,
  input  logic       CCR_Load,
  input  logic [3:0] ALU_Sel,
  input  logic [1:0] Bus1_Sel,
  input  logic [1:0] Bus2_Sel,
  input  logic       write,
  input  logic [7:0] from_memory,
  output logic [7:0] address,
  output logic [7:0] res_address,
  output logic [7:0] res_data,
  output logic       res_we,
  output logic [7:0] IR,
  output logic       CCR_Result
);

  logic [7:0]  r_pc, r_mar, r_ir, r_a, r_b, r_c, r_pr, r_marr;
  logic [3:0]  r_ccr;
  logic [7:0]  w_bus1, w_bus2;
  logic [7:0]  w_alu_res, w_flag_src;
  logic        w_alu_v, w_alu_cf;
  logic [8:0]  w_sum, w_diff;
  logic [15:0] w_prod;
  logic        w_add_v, w_sub_v;

  always_comb begin
    w_bus1 = r_pc;
    case (Bus1_Sel)
      2'b00:   w_bus1 = r_pc;
      2'b01:   w_bus1 = r_a;
      2'b10:   w_bus1 = r_b;
      default: w_bus1 = r_pr;
    endcase
  end

  always_comb begin
    w_bus2 = w_alu_res;
    case (Bus2_Sel)
      2'b00:   w_bus2 = w_alu_res;
      2'b01:   w_bus2 = IMM_VALUE;
      2'b10:   w_bus2 = from_memory;
      default: w_bus2 = r_c;
    endcase
  end

  assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff  = {1'b0, r_a} - {1'b0, r_b};
  assign w_prod  = {8'h00, r_a} * {8'h00, r_b};
  assign w_add_v = (r_a[7] == r_b[7]) && (w_sum[7] != r_a[7]);
  assign w_sub_v = (r_a[7] != r_b[7]) && (w_diff[7] != r_a[7]);

  always_comb begin
    w_alu_res  = 8'h00;
    w_alu_v    = 1'b0;
    w_alu_cf   = 1'b0;
    w_flag_src = 8'h00;
    case (ALU_Sel)
      4'h0: begin w_alu_res = w_sum[7:0];  w_alu_cf = w_sum[8];  w_alu_v = w_add_v; end
      4'h1: begin w_alu_res = w_diff[7:0]; w_alu_cf = w_diff[8]; w_alu_v = w_sub_v; end
      4'h2: begin w_alu_res = w_prod[7:0]; w_alu_cf = |w_prod[15:8]; w_alu_v = |w_prod[15:8]; end
      4'h3: begin
        if (r_b == 8'h00) begin w_alu_res = 8'hFF; w_alu_v = 1'b1; end
        else              w_alu_res = r_a / r_b;
      end
      4'h4: begin
        if (r_b == 8'h00) begin w_alu_res = r_a; w_alu_v = 1'b1; end
        else              w_alu_res = r_a % r_b;
      end
      4'h5: begin w_alu_res = r_a; w_alu_cf = w_diff[8]; w_alu_v = w_sub_v; end
      4'h6: w_alu_res = r_a & r_b;
      4'h7: w_alu_res = r_a | r_b;
      4'h8: w_alu_res = ~r_a;
      4'hA: w_alu_res = r_a ^ r_b;
      4'hB: w_alu_res = ~(r_a & r_b);
      4'hC: w_alu_res = ~(r_a | r_b);
      4'hD: w_alu_res = ~(r_a ^ r_b);
      default: w_alu_res = 8'h00;
    endcase
    // Compare passes A through but its N/Z describe A-B
    w_flag_src = (ALU_Sel == 4'h5) ? w_diff[7:0] : w_alu_res;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc   <= PC_RESET;
      r_pr   <= PR_RESET;
      r_ir   <= 8'h00;
      r_mar  <= 8'h00;
      r_marr <= 8'h00;
      r_a    <= 8'h00;
      r_b    <= 8'h00;
      r_c    <= 8'h00;
      r_ccr  <= 4'h0;
    end else begin
      if (PC_Load)      r_pc <= w_bus2;
      else if (PC_Inc)  r_pc <= r_pc + 8'h01;
      if (IR_Load)   r_ir   <= w_bus2;
      if (MAR_Load)  r_mar  <= w_bus1;
      if (MARR_Load) r_marr <= r_pr;
      if (PR_Load)   r_pr   <= w_bus2;
      if (A_Load)    r_a    <= w_bus2;
      if (B_Load)    r_b    <= w_bus2;
      if (C_Load)    r_c    <= w_alu_res;
      if (CCR_Load)  r_ccr  <= {w_flag_src[7], (w_flag_src == 8'h00), w_alu_v, w_alu_cf};
    end
  end

  always_comb begin
    CCR_Result = 1'b1;
    case (r_ir[1:0])
      2'b00:   CCR_Result = 1'b1;
      2'b01:   CCR_Result = r_ccr[2];
      2'b10:   CCR_Result = r_ccr[3];
      default: CCR_Result = r_ccr[0];
    endcase
  end

  assign address     = r_mar;
  assign res_address = r_marr;
  assign res_data    = r_c;
  assign res_we      = write;
  assign IR          = r_ir;

endmodule
